iob_axis2fifo_skid: RTL
=======================

Name: iob_axis2fifo_skid

Overview:
AXI-Stream sink that writes beats into a downstream FIFO write port. It is the parametrised successor of the single-frame AXIS-to-FIFO adapter.
- Registered tready_o with a one-entry skid slot, so no beat is lost and throughput stays at one beat per cycle when the FIFO is not full.
- Optional tlast storage in the FIFO word.
- Single-frame or continuous multi-frame mode, with per-frame beat counting and a frame counter.
- Programmable maximum frame length with overflow drain.
Sits between DMA/stream sources and iob_fifo_sync/async write ports.

Parameters:
DATA_W, 32, AXIS tdata width
AXIS_LEN_W, 16, beat-counter width (len_o, last_len_o, max_len_i)
FRAME_CNT_W, 8, frame-counter width
STORE_TLAST, 0, 1: fifo_wdata_o MSB carries tlast; 0: fifo_wdata_o = tdata only

Ports:
clk_i  in  1  clock
cke_i  in  1  clock enable; all state frozen when low
arst_n_i  in  1  asynchronous reset, active-low
rst_i  in  1  synchronous clear, active-high; dominates all other inputs
en_i  in  1  run enable
mode_i  in  1  0 = single frame, 1 = continuous; sampled only in IDLE
max_len_i  in  AXIS_LEN_W  max beats per frame; 0 = unlimited
len_o  out  AXIS_LEN_W  beats written in current frame
last_len_o  out  AXIS_LEN_W  length of last completed frame
frame_cnt_o  out  FRAME_CNT_W  completed frames, wraps modulo 2^FRAME_CNT_W
done_o  out  1  single mode: frame complete (sticky)
overflow_o  out  1  sticky: a frame exceeded max_len_i
axis_tdata_i  in  DATA_W  stream data
axis_tvalid_i  in  1  stream valid
axis_tready_o  out  1  stream ready, registered
axis_tlast_i  in  1  end of frame
fifo_full_i  in  1  FIFO full
fifo_wdata_o  out  DATA_W+STORE_TLAST  FIFO write data ({tlast,tdata} when STORE_TLAST=1)
fifo_write_o  out  1  FIFO write strobe

Behaviour:
- Interface: one clock, clk_i. Reset is asynchronous and active-low on arst_n_i.
- Reset (arst_n_i=0 or rst_i=1):
  - all outputs 0; skid slot emptied and its contents discarded; state IDLE.
- Acceptance: a beat is accepted when axis_tvalid_i & axis_tready_o.
- Source select: source = skid slot if occupied, else the live input beat. The live input path is combinational, with zero latency to fifo_write_o.
- FIFO write: fifo_write_o = source_valid & ~fifo_full_i & (state==RUN). fifo_wdata_o follows the source.
- Skid fill: an accepted beat that is not written this cycle (fifo_full_i=1) is stored in the skid slot.
- Ready rule: axis_tready_o(next) = en_i & (state==RUN) & ~fifo_full_i & skid slot empty after this cycle. A beat accepted while tready_o=1 is therefore never lost.
- States:
  - IDLE: tready low. Moves to RUN when en_i=1; latches mode_i.
  - RUN: writes beats.
    - Each write increments len_o; len_o saturates at all-ones.
    - Write with tlast: last_len_o <= len_o+1, len_o <= 0, frame_cnt_o++. Single mode -> DONE with done_o=1. Continuous mode -> stay in RUN.
    - Over-length: with max_len_i != 0 and len_o == max_len_i, the next beat without a preceding tlast is not written. overflow_o <= 1; state -> DRAIN.
  - DRAIN: accepts and discards beats with tready held high, ignoring fifo_full_i. The tlast beat is also discarded, then the frame closes as above: last_len_o = max_len_i, frame_cnt_o++. Next state is DONE (single mode) or RUN (continuous mode).
  - DONE: tready low; done_o held. Exited only by rst_i, to IDLE.
- en_i falling in RUN:
  - tready deasserts next cycle; a skid beat still flushes to the FIFO.
  - Once the skid slot is empty -> IDLE. Counters are kept, so a pause is not a clear.
- Simultaneous events:
  - tlast in the skid slot with FIFO full: write, count and done_o all occur on the cycle the write happens.
  - rst_i overrides everything.
- The max_len_i check uses the value present at each write. Lowering it below len_o mid-frame triggers overflow on the next non-tlast beat.

Decomposition:
- Package iob_axis2fifo_skid_pkg: state encoding localparams IDLE=0, RUN=1, DRAIN=2, DONE=3 (2 bits); FIFO word width DATA_W+STORE_TLAST.
- One sub-module, iob_skid_buf:
  - one-entry slot plus registered ready;
  - parameter DATA_W+1 (tdata and tlast).
- Counters use iob_counter-style registers with synchronous clear. All flops on clk_i/cke_i/arst_n_i.

Test Plan:
1. Single mode, max_len_i=0: 8-beat frame, tvalid continuous, FIFO never full -> 8 consecutive writes; last_len_o=8, frame_cnt_o=1, done_o=1 on the cycle after the 8th write; tready_o=0 afterwards.
2. Backpressure: fifo_full_i=1 for 3 cycles mid-frame while tvalid=1 -> exactly one beat held in the skid slot; tready_o low the cycle after; no beat lost or duplicated (data sequence 0..15 intact in FIFO).
3. Continuous mode: three frames of lengths 4, 1, 7 -> frame_cnt_o=3, last_len_o=7, done_o=0, 12 writes total.
4. Overflow: max_len_i=5, frame of 9 beats -> 5 writes; overflow_o=1; beats 6..9 discarded; last_len_o=5; frame_cnt_o increments once.
5. STORE_TLAST=1, DATA_W=8: frame 0xA1, 0xA2 -> FIFO words 0x0A1, 0x1A2.
6. Reset mid-frame: skid slot occupied, then arst_n_i pulsed low for 1 cycle -> all outputs 0, no further fifo_write_o; same via rst_i synchronously; then en_i=1 restarts cleanly.

Source files
------------

// File: rtl/iob_axis2fifo_skid_pkg.sv
// Shared types and helpers for the AXI-Stream to FIFO skid adapter.
package iob_axis2fifo_skid_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // FIFO word carries tlast above tdata when tlast storage is enabled.
    function automatic int unsigned fifo_word_w(input int unsigned data_w,
                                                input int unsigned store_tlast);
        return data_w + store_tlast;
    endfunction

endpackage

// File: rtl/iob_skid_buf.sv
// One-entry skid slot with a registered ready; exposes the selected source beat.
module iob_skid_buf #(
    parameter int unsigned W = 33
) (
    input  logic         clk_i,
    input  logic         cke_i,
    input  logic         arst_n_i,
    input  logic         clr_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         ready_o,
    input  logic         ready_en_i,
    input  logic         pop_i,
    output logic         src_valid_o,
    output logic [W-1:0] src_data_o,
    output logic         slot_empty_nxt_o
);

    logic         slot_valid_q;
    logic         slot_valid_d;
    logic [W-1:0] slot_q;
    logic         ready_q;
    logic         ready_d;
    logic         accept;

    // Slot has priority; ready is only ever high while the slot is empty.
    assign accept           = in_valid_i & ready_q;
    assign src_valid_o      = slot_valid_q | accept;
    assign src_data_o       = slot_valid_q ? slot_q : in_data_i;
    assign slot_valid_d     = src_valid_o & ~pop_i;
    assign slot_empty_nxt_o = ~slot_valid_d;
    assign ready_d          = ready_en_i & ~slot_valid_d;
    assign ready_o          = ready_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
            ready_q      <= 1'b0;
        end else if (cke_i) begin
            if (clr_i) begin
                slot_valid_q <= 1'b0;
                slot_q       <= '0;
                ready_q      <= 1'b0;
            end else begin
                slot_valid_q <= slot_valid_d;
                if (slot_valid_d) begin
                    slot_q <= src_data_o;
                end
                ready_q <= ready_d;
            end
        end
    end

endmodule

// File: rtl/iob_axis2fifo_skid.sv
// AXI-Stream sink writing beats into a FIFO write port, with skid slot,
// per-frame beat counting, frame counter and max-length overflow drain.
module iob_axis2fifo_skid
    import iob_axis2fifo_skid_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned AXIS_LEN_W  = 16,
    parameter int unsigned FRAME_CNT_W = 8,
    parameter int unsigned STORE_TLAST = 0
) (
    input  logic                                       clk_i,
    input  logic                                       cke_i,
    input  logic                                       arst_n_i,
    input  logic                                       rst_i,
    input  logic                                       en_i,
    input  logic                                       mode_i,
    input  logic [AXIS_LEN_W-1:0]                      max_len_i,
    output logic [AXIS_LEN_W-1:0]                      len_o,
    output logic [AXIS_LEN_W-1:0]                      last_len_o,
    output logic [FRAME_CNT_W-1:0]                     frame_cnt_o,
    output logic                                       done_o,
    output logic                                       overflow_o,
    input  logic [DATA_W-1:0]                          axis_tdata_i,
    input  logic                                       axis_tvalid_i,
    output logic                                       axis_tready_o,
    input  logic                                       axis_tlast_i,
    input  logic                                       fifo_full_i,
    output logic [fifo_word_w(DATA_W, STORE_TLAST)-1:0] fifo_wdata_o,
    output logic                                       fifo_write_o
);

    localparam int unsigned WORD_W = fifo_word_w(DATA_W, STORE_TLAST);
    localparam int unsigned SKID_W = DATA_W + 1;

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [AXIS_LEN_W-1:0]  len_q, len_d;
    logic [AXIS_LEN_W-1:0]  last_len_q, last_len_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;

    logic                   src_valid;
    logic [SKID_W-1:0]      src_data;
    logic                   src_last;
    logic [DATA_W-1:0]      src_tdata;
    logic                   slot_empty_nxt;
    logic                   at_limit;
    logic                   over_c;
    logic                   wr_c;
    logic                   drop_c;
    logic                   pop;
    logic                   ready_en;
    logic [AXIS_LEN_W-1:0]  len_inc;
    logic [WORD_W-1:0]      word_c;

    iob_skid_buf #(
        .W(SKID_W)
    ) u_skid (
        .clk_i           (clk_i),
        .cke_i           (cke_i),
        .arst_n_i        (arst_n_i),
        .clr_i           (rst_i),
        .in_data_i       ({axis_tlast_i, axis_tdata_i}),
        .in_valid_i      (axis_tvalid_i),
        .ready_o         (axis_tready_o),
        .ready_en_i      (ready_en),
        .pop_i           (pop),
        .src_valid_o     (src_valid),
        .src_data_o      (src_data),
        .slot_empty_nxt_o(slot_empty_nxt)
    );

    assign src_last  = src_data[DATA_W];
    assign src_tdata = src_data[DATA_W-1:0];

    // A tlast beat at the limit still closes the frame normally.
    assign at_limit = (max_len_i != '0) && (len_q >= max_len_i);
    assign over_c   = (state_q == RUN) & src_valid & at_limit & ~src_last;
    assign wr_c     = (state_q == RUN) & src_valid & ~fifo_full_i & ~over_c;
    assign drop_c   = (state_q == DRAIN) & src_valid;
    assign pop      = wr_c | over_c | drop_c;
    assign ready_en = en_i & (((state_d == RUN) & ~fifo_full_i) | (state_d == DRAIN));
    assign len_inc  = (len_q == '1) ? len_q : len_q + AXIS_LEN_W'(1);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        last_len_d  = last_len_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = RUN;
                    mode_d  = mode_i;
                end
            end
            RUN: begin
                if (over_c) begin
                    overflow_d = 1'b1;
                    state_d    = DRAIN;
                end else if (wr_c && src_last) begin
                    last_len_d  = len_inc;
                    len_d       = '0;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    if (!mode_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (!en_i && slot_empty_nxt) begin
                        state_d = IDLE;
                    end
                end else begin
                    if (wr_c) begin
                        len_d = len_inc;
                    end
                    // Pause: leave only once nothing is pending in the slot.
                    if (!en_i && slot_empty_nxt) begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (drop_c && src_last) begin
                    last_len_d  = max_len_i;
                    len_d       = '0;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    if (mode_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            len_q       <= '0;
            last_len_q  <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (cke_i) begin
            if (rst_i) begin
                state_q     <= IDLE;
                mode_q      <= 1'b0;
                len_q       <= '0;
                last_len_q  <= '0;
                frame_cnt_q <= '0;
                done_q      <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                state_q     <= state_d;
                mode_q      <= mode_d;
                len_q       <= len_d;
                last_len_q  <= last_len_d;
                frame_cnt_q <= frame_cnt_d;
                done_q      <= done_d;
                overflow_q  <= overflow_d;
            end
        end
    end

    generate
        if (STORE_TLAST != 0) begin : g_word_tlast
            assign word_c = {src_last, src_tdata};
        end else begin : g_word_data
            assign word_c = src_tdata;
        end
    endgenerate

    // Strobe is qualified by cke so a frozen cycle never writes twice.
    assign fifo_write_o = wr_c & cke_i & ~rst_i;
    assign fifo_wdata_o = (src_valid && !rst_i) ? word_c : '0;

    assign len_o       = len_q;
    assign last_len_o  = last_len_q;
    assign frame_cnt_o = frame_cnt_q;
    assign done_o      = done_q;
    assign overflow_o  = overflow_q;

endmodule
